// File: rtl/c_one_hot_mon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : c_one_hot_mon_pkg                                               |
// | Brief  : Reset-type constants and width helpers for the one-hot monitor. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package c_one_hot_mon_pkg;

    localparam int c_reset_type_async = 0;
    localparam int c_reset_type_sync  = 1;

    // Ceiling log2; clogb(1) == 0.
    function automatic int clogb(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int chan_bits(input int n);
        return (clogb(n) < 1) ? 1 : clogb(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/c_one_hot_mon_det.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : c_one_hot_mon_det                                               |
// | Brief  : Combinational zero-or-one-hot detector (popcount <= 1).         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module c_one_hot_mon_det #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_one_hot
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    // Clearing the lowest set bit leaves zero only when at most one bit was set.
    assign o_one_hot = ((i_data & (i_data - c_one)) == '0);

endmodule
`default_nettype wire

// File: rtl/c_one_hot_mon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : c_one_hot_mon                                                   |
// | Brief  : Registered multi-channel one-hot checker with sticky flags,     |
// |          saturating violation counter and optional first-error capture |
// |          (enabled by defining C_ONE_HOT_MON_CAPTURE_EN).                 |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module c_one_hot_mon
    import c_one_hot_mon_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_VECTORS = 4,
    parameter int ALLOW_ZERO  = 1,
    parameter int CNT_WIDTH   = 8,
    parameter int RESET_TYPE  = c_reset_type_async
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              active,
    input  logic [NUM_VECTORS-1:0]            valid_in,
    input  logic [NUM_VECTORS*WIDTH-1:0]      data_in,
    input  logic                              clear,
    output logic [NUM_VECTORS-1:0]            error_sticky,
    output logic                              error_any,
    output logic [CNT_WIDTH-1:0]              viol_count,
    output logic                              first_valid,
    output logic [chan_bits(NUM_VECTORS)-1:0] first_chan,
    output logic [WIDTH-1:0]                  first_data
);

    localparam int c_chan_w = chan_bits(NUM_VECTORS);
    localparam int c_add_w  = clogb(NUM_VECTORS + 1);
    localparam int c_sum_w  = CNT_WIDTH + c_add_w;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    if (RESET_TYPE != c_reset_type_async) begin : g_reset_check
        $error("c_one_hot_mon supports only c_reset_type_async");
    end

    logic [NUM_VECTORS-1:0]       r_s1_valid;
    logic [NUM_VECTORS*WIDTH-1:0] r_s1_data;
    logic [NUM_VECTORS-1:0]       r_s2_viol;
    logic [NUM_VECTORS-1:0]       w_le_one;
    logic [NUM_VECTORS-1:0]       w_legal;
    logic [NUM_VECTORS-1:0]       w_viol;
    logic [NUM_VECTORS-1:0]       r_sticky;
    logic [CNT_WIDTH-1:0]         r_count;
    logic [c_add_w-1:0]           w_add;
    logic [c_sum_w-1:0]           w_sum;
    logic [CNT_WIDTH-1:0]         w_count_next;

    for (genvar c = 0; c < NUM_VECTORS; c++) begin : g_chan
        c_one_hot_mon_det #(.WIDTH(WIDTH)) u_det (
            .i_data    (r_s1_data[c*WIDTH +: WIDTH]),
            .o_one_hot (w_le_one[c])
        );
        if (ALLOW_ZERO != 0) begin : g_zero_ok
            assign w_legal[c] = w_le_one[c];
        end else begin : g_need_one
            assign w_legal[c] = w_le_one[c] & (|r_s1_data[c*WIDTH +: WIDTH]);
        end
    end

    assign w_viol = r_s1_valid & ~w_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= '0;
            r_s1_data  <= '0;
            r_s2_viol  <= '0;
        end else begin
            r_s1_valid <= active ? valid_in : '0;
            if (active) begin
                r_s1_data <= data_in;
            end
            r_s2_viol <= w_viol;
        end
    end

    always_comb begin
        w_add = '0;
        for (int c = 0; c < NUM_VECTORS; c++) begin
            w_add = w_add + c_add_w'(r_s2_viol[c]);
        end
    end

    // Clear restarts the count from zero before this cycle's violations are added.
    assign w_sum        = (clear ? '0 : c_sum_w'(r_count)) + c_sum_w'(w_add);
    assign w_count_next = (w_sum > c_sum_w'(c_cnt_max)) ? c_cnt_max : w_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= '0;
            r_count  <= '0;
        end else begin
            r_sticky <= clear ? r_s2_viol : (r_sticky | r_s2_viol);
            r_count  <= w_count_next;
        end
    end

    assign error_sticky = r_sticky;
    assign error_any    = |r_sticky;
    assign viol_count   = r_count;

`ifdef C_ONE_HOT_MON_CAPTURE_EN
    logic [NUM_VECTORS*WIDTH-1:0] r_s2_data;
    logic                         r_first_valid;
    logic [c_chan_w-1:0]          r_first_chan;
    logic [WIDTH-1:0]             r_first_data;
    logic [c_chan_w-1:0]          w_low_chan;
    logic [WIDTH-1:0]             w_low_data;
    logic                         w_load;

    always_comb begin
        w_low_chan = '0;
        w_low_data = '0;
        for (int c = NUM_VECTORS - 1; c >= 0; c--) begin
            if (r_s2_viol[c]) begin
                w_low_chan = c_chan_w'(c);
                w_low_data = r_s2_data[c*WIDTH +: WIDTH];
            end
        end
    end

    assign w_load = (|r_s2_viol) & (clear | ~r_first_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_data     <= '0;
            r_first_valid <= 1'b0;
            r_first_chan  <= '0;
            r_first_data  <= '0;
        end else begin
            r_s2_data <= r_s1_data;
            if (w_load) begin
                r_first_valid <= 1'b1;
                r_first_chan  <= w_low_chan;
                r_first_data  <= w_low_data;
            end else if (clear) begin
                r_first_valid <= 1'b0;
                r_first_chan  <= '0;
                r_first_data  <= '0;
            end
        end
    end

    assign first_valid = r_first_valid;
    assign first_chan  = r_first_chan;
    assign first_data  = r_first_data;
`else
    assign first_valid = 1'b0;
    assign first_chan  = '0;
    assign first_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_c_one_hot_mon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_c_one_hot_mon                                                |
// | Brief  : Self-checking bench for c_one_hot_mon, three configurations.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_c_one_hot_mon;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active = 1'b0;
    logic [3:0]  valid_in = '0;
    logic [63:0] data16 = '0;
    logic [31:0] data8 = '0;
    logic        clear = 1'b0;

    logic [3:0] a_sticky, b_sticky, c_sticky;
    logic       a_any, b_any, c_any;
    logic [7:0] a_cnt, c_cnt;
    logic [2:0] b_cnt;
    logic       a_fv, b_fv, c_fv;
    logic [1:0] a_fc, b_fc, c_fc;
    logic [15:0] a_fd, b_fd;
    logic [7:0]  c_fd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    c_one_hot_mon #(.WIDTH(16), .NUM_VECTORS(4), .ALLOW_ZERO(1), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .active(active), .valid_in(valid_in), .data_in(data16),
        .clear(clear), .error_sticky(a_sticky), .error_any(a_any), .viol_count(a_cnt),
        .first_valid(a_fv), .first_chan(a_fc), .first_data(a_fd));

    c_one_hot_mon #(.WIDTH(16), .NUM_VECTORS(4), .ALLOW_ZERO(0), .CNT_WIDTH(3)) dut_b (
        .clk(clk), .reset(reset), .active(active), .valid_in(valid_in), .data_in(data16),
        .clear(clear), .error_sticky(b_sticky), .error_any(b_any), .viol_count(b_cnt),
        .first_valid(b_fv), .first_chan(b_fc), .first_data(b_fd));

    c_one_hot_mon #(.WIDTH(8), .NUM_VECTORS(4), .ALLOW_ZERO(0), .CNT_WIDTH(8)) dut_c (
        .clk(clk), .reset(reset), .active(active), .valid_in(valid_in), .data_in(data8),
        .clear(clear), .error_sticky(c_sticky), .error_any(c_any), .viol_count(c_cnt),
        .first_valid(c_fv), .first_chan(c_fc), .first_data(c_fd));

    logic [3:0]  o_sticky [3];
    logic [2:0]  o_any;
    logic [7:0]  o_cnt [3];
    logic [2:0]  o_fv;
    logic [1:0]  o_fc [3];
    logic [15:0] o_fd [3];
    assign o_sticky[0] = a_sticky;
    assign o_sticky[1] = b_sticky;
    assign o_sticky[2] = c_sticky;
    assign o_any = {c_any, b_any, a_any};
    assign o_cnt[0] = a_cnt;
    assign o_cnt[1] = {5'b0, b_cnt};
    assign o_cnt[2] = c_cnt;
    assign o_fv = {c_fv, b_fv, a_fv};
    assign o_fc[0] = a_fc;
    assign o_fc[1] = b_fc;
    assign o_fc[2] = c_fc;
    assign o_fd[0] = a_fd;
    assign o_fd[1] = b_fd;
    assign o_fd[2] = {8'h00, c_fd};

`ifdef C_ONE_HOT_MON_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    // Reference model: a sample taken at an edge is judged two edges later.
    int          m_az  [3] = '{1, 0, 0};
    int          m_max [3] = '{255, 7, 255};
    logic [3:0]  m_sticky [3];
    int          m_cnt [3];
    logic        m_fv [3];
    logic [1:0]  m_fc [3];
    logic [15:0] m_fd [3];
    logic [3:0]  mid_v, old_v;
    logic [3:0][15:0] mid_d, old_d;
    logic [3:0][7:0]  mid_e, old_e;

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_sticky[m] = '0; m_cnt[m] = 0; m_fv[m] = 1'b0; m_fc[m] = '0; m_fd[m] = '0;
        end
        mid_v = '0; old_v = '0; mid_d = '0; old_d = '0; mid_e = '0; old_e = '0;
    endtask

    task automatic model_step();
        logic [3:0] viol;
        int n;
        int ones;
        int low;
        bit legal;
        for (int m = 0; m < 3; m++) begin
            viol = '0; n = 0; low = -1;
            for (int c = 0; c < 4; c++) begin
                ones  = (m == 2) ? $countones(old_e[c]) : $countones(old_d[c]);
                legal = (m_az[m] != 0) ? (ones <= 1) : (ones == 1);
                if (old_v[c] && !legal) begin
                    viol[c] = 1'b1; n++;
                    if (low < 0) low = c;
                end
            end
            if (clear) begin
                m_sticky[m] = viol;
                m_cnt[m] = 0;
            end else begin
                m_sticky[m] = m_sticky[m] | viol;
            end
            m_cnt[m] = (m_cnt[m] + n > m_max[m]) ? m_max[m] : m_cnt[m] + n;
            if (CAP) begin
                if (n > 0 && (clear || !m_fv[m])) begin
                    m_fv[m] = 1'b1;
                    m_fc[m] = 2'(low);
                    m_fd[m] = (m == 2) ? {8'h00, old_e[low]} : old_d[low];
                end else if (clear) begin
                    m_fv[m] = 1'b0; m_fc[m] = '0; m_fd[m] = '0;
                end
            end
        end
        old_v = mid_v; old_d = mid_d; old_e = mid_e;
        mid_v = active ? valid_in : 4'b0;
        mid_d = data16; mid_e = data8;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; active = 1'b0; valid_in = '0; clear = 1'b0; data16 = '0; data8 = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_ch(input int c, input logic [15:0] d);
        data16[c*16 +: 16] = d;
        data8[c*8 +: 8] = d[7:0];
    endtask

    task automatic test_reset();
        do_reset();
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (o_sticky[m] !== 4'b0 || o_any[m] !== 1'b0 || o_cnt[m] !== 8'd0 ||
                o_fv[m] !== 1'b0 || o_fc[m] !== 2'd0 || o_fd[m] !== 16'h0) begin
                errors++;
                $display("FAIL reset dut%0d got st=%b cnt=%0d fv=%b fc=%0d fd=%h want all 0",
                         m, o_sticky[m], o_cnt[m], o_fv[m], o_fc[m], o_fd[m]);
            end
        end
    endtask

    task automatic test_legal_stream();
        do_reset();
        active = 1'b1; valid_in = 4'hF;
        for (int i = 0; i < 100; i++) begin
            for (int c = 0; c < 4; c++) begin
                data16[c*16 +: 16] = 16'h1 << $urandom_range(0, 15);
                data8[c*8 +: 8] = 8'h1 << $urandom_range(0, 7);
            end
            tick();
        end
        active = 1'b0;
        tick(); tick();
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (o_any[m] !== 1'b0 || o_cnt[m] !== 8'd0 || o_fv[m] !== 1'b0) begin
                errors++;
                $display("FAIL legal_stream dut%0d got any=%b cnt=%0d fv=%b want 0/0/0",
                         m, o_any[m], o_cnt[m], o_fv[m]);
            end
        end
    endtask

    task automatic test_zero_vector();
        do_reset();
        set_ch(0, 16'h0001); set_ch(1, 16'h0010); set_ch(2, 16'h0000); set_ch(3, 16'h0080);
        active = 1'b1; valid_in = 4'hF;
        tick();
        active = 1'b0;
        tick();
        checks++;
        if (b_sticky !== 4'b0000) begin
            errors++; $display("FAIL zero_latency got st=%b want 0000", b_sticky);
        end
        tick();
        checks++;
        if (a_sticky !== 4'b0000 || a_cnt !== 8'd0) begin
            errors++; $display("FAIL zero_allowed got st=%b cnt=%0d want 0000/0", a_sticky, a_cnt);
        end
        checks++;
        if (b_sticky !== 4'b0100 || b_cnt !== 3'd1) begin
            errors++; $display("FAIL zero_forbidden got st=%b cnt=%0d want 0100/1", b_sticky, b_cnt);
        end
        checks++;
        if (c_sticky !== 4'b0100 || c_any !== 1'b1) begin
            errors++; $display("FAIL zero_forbidden8 got st=%b any=%b want 0100/1", c_sticky, c_any);
        end
    endtask

    task automatic test_multi_violation();
        do_reset();
        set_ch(0, 16'h0001); set_ch(1, 16'h0003); set_ch(2, 16'h0004); set_ch(3, 16'h8001);
        data8[31:24] = 8'h81;
        active = 1'b1; valid_in = 4'hF;
        tick();
        active = 1'b0;
        tick(); tick();
        checks++;
        if (a_sticky !== 4'b1010 || a_cnt !== 8'd2) begin
            errors++; $display("FAIL multi_a got st=%b cnt=%0d want 1010/2", a_sticky, a_cnt);
        end
        checks++;
        if (b_sticky !== 4'b1010 || b_cnt !== 3'd2) begin
            errors++; $display("FAIL multi_b got st=%b cnt=%0d want 1010/2", b_sticky, b_cnt);
        end
        checks++;
        if (a_fv !== CAP || a_fc !== (CAP ? 2'd1 : 2'd0) || a_fd !== (CAP ? 16'h0003 : 16'h0)) begin
            errors++; $display("FAIL multi_capture got fv=%b fc=%0d fd=%h want fv=%b", a_fv, a_fc, a_fd, CAP);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        set_ch(0, 16'h0003);
        active = 1'b1; valid_in = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        active = 1'b0;
        tick(); tick();
        checks++;
        if (b_cnt !== 3'd7) begin
            errors++; $display("FAIL saturate_b got cnt=%0d want 7", b_cnt);
        end
        checks++;
        if (a_cnt !== 8'd10) begin
            errors++; $display("FAIL saturate_a got cnt=%0d want 10", a_cnt);
        end
        active = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        active = 1'b0;
        tick(); tick();
        checks++;
        if (b_cnt !== 3'd7 || a_cnt !== 8'd15) begin
            errors++; $display("FAIL saturate_hold got b=%0d a=%0d want 7/15", b_cnt, a_cnt);
        end
    endtask

    task automatic test_clear_collision();
        do_reset();
        set_ch(3, 16'h0003);
        active = 1'b1; valid_in = 4'b1000;
        tick();
        active = 1'b0;
        tick(); tick();
        checks++;
        if (a_sticky !== 4'b1000 || a_fc !== (CAP ? 2'd3 : 2'd0)) begin
            errors++; $display("FAIL clear_pre got st=%b fc=%0d want 1000", a_sticky, a_fc);
        end
        set_ch(0, 16'h0003);
        active = 1'b1; valid_in = 4'b0001;
        tick();
        active = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (a_sticky !== 4'b0001 || a_cnt !== 8'd1) begin
            errors++; $display("FAIL clear_set got st=%b cnt=%0d want 0001/1", a_sticky, a_cnt);
        end
        checks++;
        if (a_fv !== CAP || a_fc !== 2'd0 || a_fd !== (CAP ? 16'h0003 : 16'h0)) begin
            errors++; $display("FAIL clear_capture got fv=%b fc=%0d fd=%h want fv=%b", a_fv, a_fc, a_fd, CAP);
        end
    endtask

    task automatic test_suppressed();
        do_reset();
        set_ch(0, 16'h0003); set_ch(1, 16'h0000); set_ch(2, 16'hFFFF); set_ch(3, 16'h0101);
        active = 1'b0; valid_in = 4'hF;
        tick(); tick(); tick();
        checks++;
        if (a_any !== 1'b0 || b_cnt !== 3'd0) begin
            errors++; $display("FAIL inactive got any=%b cnt=%0d want 0/0", a_any, b_cnt);
        end
        active = 1'b1; valid_in = 4'b0000;
        tick(); tick(); tick();
        checks++;
        if (b_any !== 1'b0 || a_cnt !== 8'd0) begin
            errors++; $display("FAIL unqualified got any=%b cnt=%0d want 0/0", b_any, a_cnt);
        end
        valid_in = 4'hF;
        tick();
        active = 1'b0;
        reset = 1'b1;
        model_reset();
        #2;
        checks++;
        if (a_sticky !== 4'b0 || b_cnt !== 3'd0 || a_fv !== 1'b0) begin
            errors++; $display("FAIL reset_async got st=%b cnt=%0d fv=%b want 0", a_sticky, b_cnt, a_fv);
        end
        @(negedge clk);
        reset = 1'b0;
        tick(); tick(); tick();
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (o_any[m] !== 1'b0 || o_cnt[m] !== 8'd0 || o_fv[m] !== 1'b0) begin
                errors++;
                $display("FAIL reset_midstream dut%0d got any=%b cnt=%0d fv=%b want 0", m, o_any[m], o_cnt[m], o_fv[m]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            active = ($urandom_range(0, 3) != 0);
            valid_in = 4'($urandom_range(0, 15));
            clear = ($urandom_range(0, 15) == 0);
            for (int c = 0; c < 4; c++) begin
                case ($urandom_range(0, 3))
                    0: d = 16'h0;
                    1: d = 16'h1 << $urandom_range(0, 15);
                    2: d = (16'h1 << $urandom_range(0, 7)) | (16'h1 << $urandom_range(0, 7));
                    default: d = 16'($urandom);
                endcase
                set_ch(c, d);
            end
            tick();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (o_sticky[m] !== m_sticky[m] || o_any[m] !== (m_sticky[m] != 0) ||
                    o_cnt[m] !== 8'(m_cnt[m]) || o_fv[m] !== m_fv[m] ||
                    o_fc[m] !== m_fc[m] || o_fd[m] !== m_fd[m]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d got st=%b cnt=%0d fv=%b fc=%0d fd=%h want st=%b cnt=%0d fv=%b fc=%0d fd=%h",
                             m, i, o_sticky[m], o_cnt[m], o_fv[m], o_fc[m], o_fd[m],
                             m_sticky[m], m_cnt[m], m_fv[m], m_fc[m], m_fd[m]);
                end
            end
        end
        clear = 1'b0; active = 1'b0;
    endtask

    task automatic test_sweep();
        logic [7:0] v;
        do_reset();
        active = 1'b1; valid_in = 4'hF; clear = 1'b1;
        for (int i = 0; i < 258; i++) begin
            v = 8'(i);
            for (int c = 0; c < 4; c++) data8[c*8 +: 8] = v ^ 8'(c * 8'h55);
            data16 = {$urandom, $urandom};
            if (i >= 256) active = 1'b0;
            tick();
            if (i >= 2) begin
                checks++;
                if (c_sticky !== m_sticky[2] || c_cnt !== 8'(m_cnt[2])) begin
                    errors++;
                    $display("FAIL sweep step%0d got st=%b cnt=%0d want st=%b cnt=%0d",
                             i, c_sticky, c_cnt, m_sticky[2], m_cnt[2]);
                end
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_legal_stream();
        test_zero_vector();
        test_multi_violation();
        test_saturate();
        test_clear_collision();
        test_suppressed();
        test_random();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
